// File: rtl/ex_tracker_queued.sv
// EX-stage trace tracker with an order-preserving input queue and a valid/ack output.
// Define EX_TRACKER_RVALID_EN to close memory instructions on the response (rvalid).
package ex_tracker_pkg;
    typedef struct packed {
        logic [31:0] time_start;
        logic [31:0] time_end;
    } time_span_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic        pass_through;
        time_span_t  ex_data;
        time_span_t  mem_access_req;
    } trace_output;
endpackage

module ex_tracker_queued
    import ex_tracker_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  integer                     counter,
    input  logic                       id_data_ready,
    input  trace_output                id_data_in,
    input  logic                       ex_ready,
    input  logic                       data_req_i,
    input  logic [ADDR_WIDTH-1:0]      data_addr_i,
    input  logic                       data_gnt_i,
    input  logic                       data_rvalid_i,
    input  logic                       ex_data_ack_i,
    output trace_output                ex_data_o,
    output logic                       ex_data_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
    output logic                       overflow_o,
    output logic [CNT_WIDTH-1:0]       drop_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EX_START,
        S_WAIT_GNT,
`ifdef EX_TRACKER_RVALID_EN
        S_WAIT_RVALID,
`endif
        S_OUT_HOLD
    } state_t;

    state_t          state;
    trace_output     work;
    trace_output     stamped;
    trace_output     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     last_instr;
    logic [31:0]     cnt;
    logic            full;
    logic            empty;
    logic            accept;
    logic            pop;
    logic            push;
    logic            drop;
    logic            unused_ok;

    assign cnt       = counter;
    assign full      = (fifo_level_o == LW'(DEPTH));
    assign empty     = (fifo_level_o == '0);
    assign accept    = id_data_ready && (id_data_in.instruction != last_instr);
    assign pop       = (state == S_IDLE) && !empty;
    // a full queue can still take an element when the head leaves on the same edge
    assign push      = accept && (!full || pop);
    assign drop      = accept && full && !pop;
    assign unused_ok = ^{data_addr_i, data_rvalid_i} ^ (DATA_WIDTH == 0);

    always_comb begin
        stamped = id_data_in;
        if (!id_data_in.pass_through)
            stamped.ex_data.time_start = cnt;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= stamped;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            last_instr   <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            if (accept)
                last_instr <= id_data_in.instruction;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                fifo_level_o <= fifo_level_o + LW'(1);
            else if (pop && !push)
                fifo_level_o <= fifo_level_o - LW'(1);
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != '1)
                    drop_count_o <= drop_count_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            work          <= '0;
            ex_data_o     <= '0;
            ex_data_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        work  <= mem[rd_ptr];
                        state <= mem[rd_ptr].pass_through ? S_OUT_HOLD : S_EX_START;
                    end
                end
                S_EX_START: begin
                    if (ex_ready) begin
                        work.ex_data.time_end <= cnt;
                        work.pass_through     <= 1'b1;
                        state                 <= S_OUT_HOLD;
                    end else if (data_req_i) begin
                        work.mem_access_req.time_start <= cnt;
                        state                          <= S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (data_gnt_i) begin
                        work.mem_access_req.time_end <= cnt;
                        work.pass_through            <= 1'b1;
`ifdef EX_TRACKER_RVALID_EN
                        state <= S_WAIT_RVALID;
`else
                        work.ex_data.time_end <= cnt;
                        state                 <= S_OUT_HOLD;
`endif
                    end
                end
`ifdef EX_TRACKER_RVALID_EN
                S_WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        work.ex_data.time_end <= cnt;
                        state                 <= S_OUT_HOLD;
                    end
                end
`endif
                S_OUT_HOLD: begin
                    if (ex_data_ready && ex_data_ack_i) begin
                        ex_data_ready <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        ex_data_ready <= 1'b1;
                        ex_data_o     <= work;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_tracker_queued.sv
// Directed bench for ex_tracker_queued: timing stamps, queue ordering, overflow, reset.
module tb_ex_tracker_queued;
    import ex_tracker_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    integer      counter = 0;
    logic        id_data_ready = 1'b0;
    trace_output id_data_in = '0;
    logic        ex_ready = 1'b0;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        ex_data_ack_i = 1'b0;
    trace_output ex_data_o;
    logic        ex_data_ready;
    logic [2:0]  fifo_level_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;

    int vectors = 0;
    int miscompares = 0;

    ex_tracker_queued #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .id_data_ready(id_data_ready), .id_data_in(id_data_in),
        .ex_ready(ex_ready), .data_req_i(data_req_i), .data_addr_i(data_addr_i),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .ex_data_ack_i(ex_data_ack_i), .ex_data_o(ex_data_o),
        .ex_data_ready(ex_data_ready), .fifo_level_o(fifo_level_o),
        .overflow_o(overflow_o), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) counter <= counter + 1;

    function automatic trace_output mk(input logic [31:0] ins, input logic pt);
        trace_output t;
        t = '0;
        t.instruction  = ins;
        t.pass_through = pt;
        if (pt) begin
            t.ex_data.time_start = 32'h1234;
            t.ex_data.time_end   = 32'h5678;
        end
        return t;
    endfunction

    task automatic goto_cnt(input int v);
        if (counter > v) begin
            vectors++;
            miscompares++;
            $display("FAIL goto_cnt counter %0d already past %0d", counter, v);
        end
        while (counter < v) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ex_data_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (ex_data_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout waiting for ex_data_ready", tag);
        end
    endtask

    task automatic ack_one();
        ex_data_ack_i = 1'b1;
        @(negedge clk);
        ex_data_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (ex_data_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %0b want 0", ex_data_ready); end
        vectors++; if (ex_data_o !== '0) begin miscompares++; $display("FAIL rst_data got %h want 0", ex_data_o); end
        vectors++; if (fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", fifo_level_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL rst_overflow got %0b want 0", overflow_o); end
        vectors++; if (drop_count_o !== 16'd0) begin miscompares++; $display("FAIL rst_drops got %0d want 0", drop_count_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        goto_cnt(10);
        id_data_in = mk(32'h0000_0013, 1'b0);
        id_data_ready = 1'b1;
        @(negedge clk);
        id_data_ready = 1'b0;
        goto_cnt(13);
        ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
        wait_ready("single");
        vectors++; if (ex_data_o.instruction !== 32'h13) begin miscompares++; $display("FAIL single_instr got %h want 13", ex_data_o.instruction); end
        vectors++; if (ex_data_o.ex_data.time_start !== 32'd10) begin miscompares++; $display("FAIL single_tstart got %0d want 10", ex_data_o.ex_data.time_start); end
        vectors++; if (ex_data_o.ex_data.time_end !== 32'd13) begin miscompares++; $display("FAIL single_tend got %0d want 13", ex_data_o.ex_data.time_end); end
        vectors++; if (ex_data_o.pass_through !== 1'b1) begin miscompares++; $display("FAIL single_pt got %0b want 1", ex_data_o.pass_through); end
        repeat (2) @(negedge clk);
        vectors++; if (ex_data_ready !== 1'b1) begin miscompares++; $display("FAIL single_hold got %0b want 1", ex_data_ready); end
        ack_one();
        vectors++; if (ex_data_ready !== 1'b0) begin miscompares++; $display("FAIL single_ackdrop got %0b want 0", ex_data_ready); end
    endtask

    task automatic test_mem();
        goto_cnt(20);
        id_data_in = mk(32'h0000_2003, 1'b0);
        id_data_ready = 1'b1;
        @(negedge clk);
        id_data_ready = 1'b0;
        goto_cnt(22);
        data_req_i = 1'b1;
        @(negedge clk);
        data_req_i = 1'b0;
        goto_cnt(25);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        goto_cnt(27);
        data_rvalid_i = 1'b1;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        wait_ready("mem");
        vectors++; if (ex_data_o.mem_access_req.time_start !== 32'd22) begin miscompares++; $display("FAIL mem_req_start got %0d want 22", ex_data_o.mem_access_req.time_start); end
        vectors++; if (ex_data_o.mem_access_req.time_end !== 32'd25) begin miscompares++; $display("FAIL mem_req_end got %0d want 25", ex_data_o.mem_access_req.time_end); end
        vectors++; if (ex_data_o.ex_data.time_start !== 32'd20) begin miscompares++; $display("FAIL mem_tstart got %0d want 20", ex_data_o.ex_data.time_start); end
`ifdef EX_TRACKER_RVALID_EN
        vectors++; if (ex_data_o.ex_data.time_end !== 32'd27) begin miscompares++; $display("FAIL mem_tend got %0d want 27", ex_data_o.ex_data.time_end); end
`else
        vectors++; if (ex_data_o.ex_data.time_end !== 32'd25) begin miscompares++; $display("FAIL mem_tend got %0d want 25", ex_data_o.ex_data.time_end); end
`endif
        ack_one();
    endtask

    task automatic test_pass_latency();
        trace_output p;
        p = mk(32'h0000_0400, 1'b1);
        repeat (2) @(negedge clk);
        id_data_in = p;
        id_data_ready = 1'b1;
        @(negedge clk);
        id_data_ready = 1'b0;
        vectors++; if (fifo_level_o !== 3'd1) begin miscompares++; $display("FAIL pt_level_n got %0d want 1", fifo_level_o); end
        vectors++; if (ex_data_ready !== 1'b0) begin miscompares++; $display("FAIL pt_ready_n got %0b want 0", ex_data_ready); end
        @(negedge clk);
        vectors++; if (ex_data_ready !== 1'b0) begin miscompares++; $display("FAIL pt_ready_n1 got %0b want 0", ex_data_ready); end
        @(negedge clk);
        vectors++; if (ex_data_ready !== 1'b1) begin miscompares++; $display("FAIL pt_ready_n2 got %0b want 1", ex_data_ready); end
        vectors++; if (ex_data_o !== p) begin miscompares++; $display("FAIL pt_data got %h want %h", ex_data_o, p); end
        ack_one();
    endtask

    task automatic test_dup();
        bit extra;
        id_data_in = mk(32'h0000_0300, 1'b1);
        id_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (fifo_level_o > 3'd1) begin miscompares++; $display("FAIL dup_level%0d got %0d want <=1", i, fifo_level_o); end
        end
        id_data_ready = 1'b0;
        wait_ready("dup");
        vectors++; if (ex_data_o.instruction !== 32'h300) begin miscompares++; $display("FAIL dup_instr got %h want 300", ex_data_o.instruction); end
        ack_one();
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ex_data_ready === 1'b1) extra = 1'b1;
        end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL dup_extra got %0b want 0", extra); end
    endtask

    task automatic test_overflow();
        bit extra;
        for (int i = 0; i < 6; i++) begin
            id_data_in = mk(32'h100 + i, 1'b1);
            id_data_ready = 1'b1;
            @(negedge clk);
        end
        id_data_ready = 1'b0;
        vectors++; if (fifo_level_o !== 3'd4) begin miscompares++; $display("FAIL ovf_level got %0d want 4", fifo_level_o); end
        vectors++; if (overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", overflow_o); end
        vectors++; if (drop_count_o !== 16'd1) begin miscompares++; $display("FAIL ovf_drops got %0d want 1", drop_count_o); end
        for (int k = 0; k < 5; k++) begin
            wait_ready("ovf");
            vectors++; if (ex_data_o.instruction !== 32'h100 + k) begin miscompares++; $display("FAIL ovf_order%0d got %h want %h", k, ex_data_o.instruction, 32'h100 + k); end
            ack_one();
        end
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ex_data_ready === 1'b1) extra = 1'b1;
        end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL ovf_dropped_emitted got %0b want 0", extra); end
        vectors++; if (overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %0b want 1", overflow_o); end
    endtask

    task automatic test_order();
        bit early;
        id_data_in = mk(32'h0000_0600, 1'b0);
        id_data_ready = 1'b1;
        @(negedge clk);
        id_data_in = mk(32'h0000_0601, 1'b1);
        @(negedge clk);
        id_data_ready = 1'b0;
        data_req_i = 1'b1;
        @(negedge clk);
        data_req_i = 1'b0;
        early = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ex_data_ready === 1'b1) early = 1'b1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL order_stall got %0b want 0", early); end
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        wait_ready("order_mem");
        vectors++; if (ex_data_o.instruction !== 32'h600) begin miscompares++; $display("FAIL order_first got %h want 600", ex_data_o.instruction); end
        ack_one();
        wait_ready("order_pt");
        vectors++; if (ex_data_o.instruction !== 32'h601) begin miscompares++; $display("FAIL order_second got %h want 601", ex_data_o.instruction); end
        ack_one();
    endtask

    task automatic test_rst_mid();
        bit extra;
        id_data_in = mk(32'h0000_0500, 1'b0);
        id_data_ready = 1'b1;
        @(negedge clk);
        id_data_in = mk(32'h0000_0501, 1'b1);
        @(negedge clk);
        id_data_in = mk(32'h0000_0502, 1'b1);
        data_req_i = 1'b1;
        @(negedge clk);
        id_data_ready = 1'b0;
        data_req_i = 1'b0;
        vectors++; if (fifo_level_o !== 3'd2) begin miscompares++; $display("FAIL rstmid_setup_level got %0d want 2", fifo_level_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (ex_data_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got %0b want 0", ex_data_ready); end
        vectors++; if (fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL rstmid_level got %0d want 0", fifo_level_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_overflow got %0b want 0", overflow_o); end
        @(negedge clk);
        rst = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ex_data_ready === 1'b1) extra = 1'b1;
        end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL rstmid_emitted got %0b want 0", extra); end
        vectors++; if (fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL rstmid_level_after got %0d want 0", fifo_level_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mem();
        test_pass_latency();
        test_dup();
        test_overflow();
        test_order();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
